tpu_lite_top: RTL and testbench

//  Small APB-configured 4x4 int8 matrix engine with two internal dual-port byte RAMs (A, B).

---
 rtl/tpu_lite_top.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_tpu_lite_top.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_lite_top.sv
// tpu_lite_top: APB-configured 4x4 int8 matrix engine.
//   C = A x B, then optional normalisation, ReLU and 2x2 max-pool.
//   C is written back into RAM A in the same column-major layout as A,
//   so one layer's output can be the next layer's A.
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   PADDR/PWRITE/PSEL/PENABLE/
//   PWDATA/PRDATA/PREADY           APB register port (PRDATA registered, no wait states)
//   bram_*_a_ext / bram_*_b_ext    host word ports into RAM A / RAM B
//                                  (byte enables, 1-cycle read latency)
// Register map: 0x00 ENABLES {act,pool,norm,matmul}, 0x04 STDN {done[31], start[0]},
//   0x08 MEAN, 0x0C INV_VAR, 0x10 A_ADDR, 0x14 B_ADDR, 0x18 C_ADDR.
`timescale 1ns/1ps

// Byte RAM with an independent host port and engine port (both word wide).
//   host_*  : byte-enabled write, registered word read
//   eng_*   : full-word write, registered word read
module tpu_lite_bram #(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 8,
  parameter int MASK_WIDTH = 4
) (
  input  logic                           clk,
  input  logic [AWIDTH-1:0]              host_addr_i,
  input  logic [DWIDTH*MASK_WIDTH-1:0]   host_wdata_i,
  input  logic [MASK_WIDTH-1:0]          host_we_i,
  output logic [DWIDTH*MASK_WIDTH-1:0]   host_rdata_o,
  input  logic [AWIDTH-1:0]              eng_addr_i,
  input  logic [DWIDTH*MASK_WIDTH-1:0]   eng_wdata_i,
  input  logic                           eng_we_i,
  output logic [DWIDTH*MASK_WIDTH-1:0]   eng_rdata_o
);
  logic [DWIDTH-1:0] ram [0:(1<<AWIDTH)-1];

  // Byte n of a word lives at addr+n. If both ports hit the same byte in
  // one cycle the engine write lands last and wins.
  always_ff @(posedge clk) begin
    for (int n = 0; n < MASK_WIDTH; n++) begin
      if (host_we_i[n]) ram[host_addr_i + AWIDTH'(n)] <= host_wdata_i[DWIDTH*n +: DWIDTH];
      if (eng_we_i)     ram[eng_addr_i + AWIDTH'(n)]  <= eng_wdata_i[DWIDTH*n +: DWIDTH];
      host_rdata_o[DWIDTH*n +: DWIDTH] <= ram[host_addr_i + AWIDTH'(n)];
      eng_rdata_o[DWIDTH*n +: DWIDTH]  <= ram[eng_addr_i + AWIDTH'(n)];
    end
  end
endmodule

module tpu_lite_top #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int AWIDTH        = 10,
  parameter int DWIDTH        = 8,
  parameter int MAT_MUL_SIZE  = 4,
  parameter int MASK_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REG_ADDRWIDTH-1:0]     PADDR,
  input  logic                         PWRITE,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic [REG_DATAWIDTH-1:0]     PWDATA,
  output logic [REG_DATAWIDTH-1:0]     PRDATA,
  output logic                         PREADY,
  input  logic [AWIDTH-1:0]            bram_addr_a_ext,
  input  logic [DWIDTH*MASK_WIDTH-1:0] bram_wdata_a_ext,
  input  logic [MASK_WIDTH-1:0]        bram_we_a_ext,
  output logic [DWIDTH*MASK_WIDTH-1:0] bram_rdata_a_ext,
  input  logic [AWIDTH-1:0]            bram_addr_b_ext,
  input  logic [DWIDTH*MASK_WIDTH-1:0] bram_wdata_b_ext,
  input  logic [MASK_WIDTH-1:0]        bram_we_b_ext,
  output logic [DWIDTH*MASK_WIDTH-1:0] bram_rdata_b_ext
);
  localparam int N     = MAT_MUL_SIZE;
  localparam int WW    = DWIDTH * MASK_WIDTH;
  localparam int ACC_W = 20;
  localparam int KW    = $clog2(N);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPUTE = 3'd1;
  localparam logic [2:0] S_POST    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [REG_ADDRWIDTH-1:0] R_EN    = 'h00;
  localparam logic [REG_ADDRWIDTH-1:0] R_STDN  = 'h04;
  localparam logic [REG_ADDRWIDTH-1:0] R_MEAN  = 'h08;
  localparam logic [REG_ADDRWIDTH-1:0] R_INV   = 'h0C;
  localparam logic [REG_ADDRWIDTH-1:0] R_AADDR = 'h10;
  localparam logic [REG_ADDRWIDTH-1:0] R_BADDR = 'h14;
  localparam logic [REG_ADDRWIDTH-1:0] R_CADDR = 'h18;

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DWIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DWIDTH-1:0] x);
    return {{(ACC_W-DWIDTH){x[DWIDTH-1]}}, x};
  endfunction

  function automatic logic signed [DWIDTH-1:0] sat_d(input logic signed [ACC_W-1:0] x);
    if (x > SMAX) return SMAX[DWIDTH-1:0];
    if (x < SMIN) return SMIN[DWIDTH-1:0];
    return x[DWIDTH-1:0];
  endfunction

  function automatic logic signed [DWIDTH-1:0] norm_d(input logic signed [DWIDTH-1:0] x,
                                                      input logic signed [DWIDTH-1:0] mean,
                                                      input logic signed [DWIDTH-1:0] inv);
    logic signed [ACC_W-1:0] diff;
    logic signed [ACC_W-1:0] prod;
    diff = sext(x) - sext(mean);
    prod = diff * sext(inv);
    return sat_d(prod);
  endfunction

  function automatic logic signed [DWIDTH-1:0] relu_d(input logic signed [DWIDTH-1:0] x);
    return x[DWIDTH-1] ? '0 : x;
  endfunction

  function automatic logic signed [DWIDTH-1:0] max_d(input logic signed [DWIDTH-1:0] a,
                                                     input logic signed [DWIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Element-wise chain: matmul saturation (or A passthrough), norm, ReLU.
  function automatic logic signed [DWIDTH-1:0] post_elem(input logic signed [ACC_W-1:0] acc,
                                                         input logic signed [DWIDTH-1:0] a,
                                                         input logic [3:0] en,
                                                         input logic signed [DWIDTH-1:0] mean,
                                                         input logic signed [DWIDTH-1:0] inv);
    logic signed [DWIDTH-1:0] x;
    x = en[0] ? sat_d(acc) : a;
    if (en[1]) x = norm_d(x, mean, inv);
    if (en[3]) x = relu_d(x);
    return x;
  endfunction

  // Configuration registers
  logic [3:0]               en_q;
  logic                     start_q;
  logic signed [DWIDTH-1:0] mean_q, inv_q;
  logic [AWIDTH-1:0]        a_addr_q, b_addr_q, c_addr_q;
  logic [REG_DATAWIDTH-1:0] prdata_q, rdata_d;

  // Run snapshot, taken at launch so config writes mid-run have no effect
  logic [3:0]               run_en_q;
  logic signed [DWIDTH-1:0] run_mean_q, run_inv_q;
  logic [AWIDTH-1:0]        run_a_q, run_b_q, run_c_q;

  logic [2:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          done, launch, rd_issue;
  logic          vld_p1_q;
  logic [KW-1:0] k_p1_q;

  logic [AWIDTH-1:0] word_off, eng_addr_a, eng_addr_b;
  logic [WW-1:0]     eng_rdata_a, eng_rdata_b, eng_wdata_a;
  logic              eng_we_a;

  logic signed [ACC_W-1:0]  acc_q   [N][N];
  logic signed [DWIDTH-1:0] a_mat_q [N][N];
  logic signed [DWIDTH-1:0] stage_d [N][N];
  logic signed [DWIDTH-1:0] pool_d  [N][N];
  logic signed [DWIDTH-1:0] c_q     [N][N];

  logic apb_wr, apb_rd;
  logic unused_pwdata;

  assign apb_wr        = PSEL & PENABLE & PWRITE;
  assign apb_rd        = PSEL & PENABLE & ~PWRITE;
  assign PRDATA        = prdata_q;
  assign PREADY        = 1'b1;
  assign unused_pwdata = ^PWDATA[REG_DATAWIDTH-1:AWIDTH];
  assign done          = (state_q == S_DONE);

  always_comb begin
    rdata_d = '0;
    case (PADDR)
      R_EN:    rdata_d[3:0] = en_q;
      R_STDN:  begin
        rdata_d[REG_DATAWIDTH-1] = done;
        rdata_d[0]               = start_q;
      end
      R_MEAN:  rdata_d[DWIDTH-1:0] = mean_q;
      R_INV:   rdata_d[DWIDTH-1:0] = inv_q;
      R_AADDR: rdata_d[AWIDTH-1:0] = a_addr_q;
      R_BADDR: rdata_d[AWIDTH-1:0] = b_addr_q;
      R_CADDR: rdata_d[AWIDTH-1:0] = c_addr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= '0;
      start_q  <= 1'b0;
      mean_q   <= '0;
      inv_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      prdata_q <= '0;
    end else begin
      if (apb_wr) begin
        case (PADDR)
          R_EN:    en_q     <= PWDATA[3:0];
          R_STDN:  start_q  <= PWDATA[0];
          R_MEAN:  mean_q   <= PWDATA[DWIDTH-1:0];
          R_INV:   inv_q    <= PWDATA[DWIDTH-1:0];
          R_AADDR: a_addr_q <= PWDATA[AWIDTH-1:0];
          R_BADDR: b_addr_q <= PWDATA[AWIDTH-1:0];
          R_CADDR: c_addr_q <= PWDATA[AWIDTH-1:0];
          default: ;
        endcase
      end
      if (apb_rd) prdata_q <= rdata_d;
    end
  end

  // COMPUTE runs N+1 cycles: N reads issued, the last returning one cycle later.
  // done is only ever set in S_DONE, so the IDLE launch needs just start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start_q) begin
        state_d = S_COMPUTE;
        cnt_d   = '0;
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(N)) begin
          state_d = S_POST;
          cnt_d   = '0;
        end
      end
      S_POST: begin
        state_d = S_WRITE;
        cnt_d   = '0;
      end
      S_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(N-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: if (!start_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign launch   = (state_q == S_IDLE) && (state_d == S_COMPUTE);
  assign rd_issue = (state_q == S_COMPUTE) && (cnt_q < 3'(N));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= rd_issue;
    end
  end

  always_ff @(posedge clk) begin
    k_p1_q <= cnt_q[KW-1:0];
    if (launch) begin
      run_en_q   <= en_q;
      run_mean_q <= mean_q;
      run_inv_q  <= inv_q;
      run_a_q    <= a_addr_q;
      run_b_q    <= b_addr_q;
      run_c_q    <= c_addr_q;
    end
  end

  // Engine addressing: word k of A/B while computing, C column j while writing.
  assign word_off   = AWIDTH'(int'(cnt_q) * MASK_WIDTH);
  assign eng_addr_a = (state_q == S_WRITE) ? run_c_q + word_off : run_a_q + word_off;
  assign eng_addr_b = run_b_q + word_off;

  // ---- stage p1: RAM words for step k arrive; outer-product accumulate ----
  always_ff @(posedge clk) begin
    if (launch) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc_q[i][j] <= '0;
    end else if (vld_p1_q) begin
      for (int i = 0; i < N; i++) begin
        a_mat_q[i][k_p1_q] <= eng_rdata_a[DWIDTH*i +: DWIDTH];
        for (int j = 0; j < N; j++)
          acc_q[i][j] <= acc_q[i][j] + sext(eng_rdata_a[DWIDTH*i +: DWIDTH]) *
                                       sext(eng_rdata_b[DWIDTH*j +: DWIDTH]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        stage_d[i][j] = post_elem(acc_q[i][j], a_mat_q[i][j], run_en_q, run_mean_q, run_inv_q);
  end

  // Pool keeps the 4x4 shape: each 2x2 block max is broadcast to all four cells.
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pool_d[i][j] = stage_d[i][j];
        if (run_en_q[2])
          pool_d[i][j] = max_d(max_d(stage_d[i & ~1][j & ~1], stage_d[i | 1][j & ~1]),
                               max_d(stage_d[i & ~1][j | 1],  stage_d[i | 1][j | 1]));
      end
  end

  // ---- stage p2: POST registers the finished matrix for write-back ----
  always_ff @(posedge clk) begin
    if (state_q == S_POST) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c_q[i][j] <= pool_d[i][j];
    end
  end

  always_comb begin
    eng_wdata_a = '0;
    for (int i = 0; i < N; i++)
      eng_wdata_a[DWIDTH*i +: DWIDTH] = c_q[i][cnt_q[KW-1:0]];
  end

  // Gated by reset so a reset landing on a WRITE cycle leaves RAM untouched.
  assign eng_we_a = (state_q == S_WRITE) && !reset;

  tpu_lite_bram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .MASK_WIDTH(MASK_WIDTH)) matrix_A (
    .clk          (clk),
    .host_addr_i  (bram_addr_a_ext),
    .host_wdata_i (bram_wdata_a_ext),
    .host_we_i    (bram_we_a_ext),
    .host_rdata_o (bram_rdata_a_ext),
    .eng_addr_i   (eng_addr_a),
    .eng_wdata_i  (eng_wdata_a),
    .eng_we_i     (eng_we_a),
    .eng_rdata_o  (eng_rdata_a)
  );

  tpu_lite_bram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .MASK_WIDTH(MASK_WIDTH)) matrix_B (
    .clk          (clk),
    .host_addr_i  (bram_addr_b_ext),
    .host_wdata_i (bram_wdata_b_ext),
    .host_we_i    (bram_we_b_ext),
    .host_rdata_o (bram_rdata_b_ext),
    .eng_addr_i   (eng_addr_b),
    .eng_wdata_i  ('0),
    .eng_we_i     (1'b0),
    .eng_rdata_o  (eng_rdata_b)
  );
endmodule

// File: tb/tb_tpu_lite_top.sv
// Self-checking bench for tpu_lite_top: directed register/matrix cases plus
// randomized matrices and configurations checked against an arithmetic model.
`timescale 1ns/1ps
module tb_tpu_lite_top;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  we_a, we_b;
  logic [31:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  tpu_lite_top dut (
    .clk              (clk),
    .reset            (reset),
    .PADDR            (PADDR),
    .PWRITE           (PWRITE),
    .PSEL             (PSEL),
    .PENABLE          (PENABLE),
    .PWDATA           (PWDATA),
    .PRDATA           (PRDATA),
    .PREADY           (PREADY),
    .bram_addr_a_ext  (addr_a),
    .bram_wdata_a_ext (wdata_a),
    .bram_we_a_ext    (we_a),
    .bram_rdata_a_ext (rdata_a),
    .bram_addr_b_ext  (addr_b),
    .bram_wdata_b_ext (wdata_b),
    .bram_we_b_ext    (we_b),
    .bram_rdata_b_ext (rdata_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mA[4][4], mB[4][4], mC[4][4];
  int mEn, mMean, mInv, mCbase;

  logic [31:0] dA[4] = '{32'h09050308, 32'h01020304, 32'h00010306, 32'h05060708};
  logic [31:0] dB[4] = '{32'h00030101, 32'h03040100, 32'h01030503, 32'h02030609};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    @(posedge clk);
    #1;
    d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic host_wr(input bit sel_b, input int a, input logic [31:0] d);
    @(negedge clk);
    if (sel_b) begin addr_b = 10'(a); wdata_b = d; we_b = 4'hF; end
    else       begin addr_a = 10'(a); wdata_a = d; we_a = 4'hF; end
    @(negedge clk);
    we_a = 4'h0; we_b = 4'h0;
  endtask

  function automatic logic [7:0] ram_a(input int idx);
    return dut.matrix_A.ram[idx & 1023];
  endfunction

  function automatic int sat8(input int x);
    return (x > 127) ? 127 : ((x < -128) ? -128 : x);
  endfunction

  function automatic int sbyte(input logic [7:0] b);
    return int'(b) - ((b >= 8'h80) ? 256 : 0);
  endfunction

  task automatic set_directed();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        mA[i][k] = sbyte(dA[k][8*i +: 8]);
        mB[k][i] = sbyte(dB[k][8*i +: 8]);
      end
  endtask

  // A column k is one word (byte i = A[i][k]); B row k is one word (byte j = B[k][j]).
  task automatic load_A(input int base);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(mA[i][k]);
      host_wr(1'b0, base + 4*k, w);
    end
  endtask

  task automatic load_B(input int base);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(mB[k][j]);
      host_wr(1'b1, base + 4*k, w);
    end
  endtask

  task automatic model();
    int t[4][4];
    int v, s, m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (mEn[0]) begin
          s = 0;
          for (int k = 0; k < 4; k++) s += mA[i][k] * mB[k][j];
          v = sat8(s);
        end else v = mA[i][j];
        if (mEn[1]) v = sat8((v - mMean) * mInv);
        if (mEn[3] && v < 0) v = 0;
        t[i][j] = v;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (mEn[2]) begin
          m = -1000;
          for (int di = 0; di < 2; di++)
            for (int dj = 0; dj < 2; dj++)
              if (t[(i/2)*2+di][(j/2)*2+dj] > m) m = t[(i/2)*2+di][(j/2)*2+dj];
          mC[i][j] = m;
        end else mC[i][j] = t[i][j];
      end
  endtask

  task automatic check_c(input string tag);
    model();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("%s C[%0d][%0d]", tag, i, j),
                 32'(ram_a(mCbase + 4*j + i)), 32'(mC[i][j] & 255));
  endtask

  task automatic configure(input int en, input int mean, input int inv,
                           input int aa, input int ba, input int ca);
    mEn = en; mMean = mean; mInv = inv; mCbase = ca;
    apb_write(8'h00, 32'(en));
    apb_write(8'h08, 32'(mean & 255));
    apb_write(8'h0C, 32'(inv & 255));
    apb_write(8'h10, 32'(aa));
    apb_write(8'h14, 32'(ba));
    apb_write(8'h18, 32'(ca));
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d;
    int polls;
    d = '0;
    polls = 0;
    while (!d[31] && polls < 16) begin
      apb_read(8'h04, d);
      polls++;
    end
    check_eq({tag, " done"}, 32'(d[31]), 32'd1);
  endtask

  task automatic run_engine(input string tag, input bit disturb);
    logic [31:0] d;
    apb_write(8'h04, 32'd1);
    if (disturb) begin
      apb_write(8'h00, 32'((~mEn) & 15));
      apb_write(8'h08, 32'((mMean ^ 8'h55) & 255));
      apb_write(8'h18, 32'h3F0);
    end
    wait_done(tag);
    apb_write(8'h04, 32'd0);
    apb_read(8'h04, d);
    check_eq({tag, " stdn_idle"}, d, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  exp2[4] = '{8'h62, 8'h4B, 8'h3E, 8'h36};
    logic [7:0]  exp3[4] = '{8'h61, 8'h61, 8'h3D, 8'h3D};
    logic [7:0]  keep[16];
    int en, mean, inv, aa, ba, ca, lo, hi;

    reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; we_a = '0; we_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Register access
    apb_read(8'h04, d);             check_eq("stdn_after_reset", d, 32'd0);
    apb_read(8'h00, d);             check_eq("en_after_reset", d, 32'd0);
    apb_write(8'h00, 32'hF);
    apb_read(8'h00, d);             check_eq("enables_rb", d, 32'h0000000F);
    apb_write(8'h1C, 32'hFFFFFFFF);
    apb_read(8'h1C, d);             check_eq("unmapped_rd", d, 32'd0);
    apb_write(8'h10, 32'hFFFFF3F4);
    apb_read(8'h10, d);             check_eq("a_addr_mask", d, 32'h3F4);
    repeat (3) @(negedge clk);
    check_eq("prdata_held", PRDATA, 32'h3F4);
    check_eq("pready", 32'(PREADY), 32'd1);

    // Plain matmul on the reference matrices
    set_directed();
    load_A(8'h08);
    load_B(8'h00);
    configure(1, 0, 0, 8'h08, 8'h00, 8'h20);
    run_engine("mm", 1'b0);
    for (int n = 0; n < 4; n++)
      check_eq($sformatf("mm ram[%0d]", 32 + n), 32'(ram_a(32 + n)), 32'(exp2[n]));
    check_c("mm");

    // Chain: previous C becomes A, result saturates everywhere
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) mA[i][k] = mC[i][k];
    configure(1, 0, 0, 8'h20, 8'h00, 8'h40);
    run_engine("chain", 1'b0);
    for (int n = 0; n < 16; n++)
      check_eq($sformatf("chain ram[%0d]", 64 + n), 32'(ram_a(64 + n)), 32'h7F);

    // Full pipeline with pooling
    set_directed();
    configure(15, 1, 1, 8'h08, 8'h00, 8'h20);
    run_engine("full", 1'b0);
    for (int n = 0; n < 4; n++)
      check_eq($sformatf("full ram[%0d]", 32 + n), 32'(ram_a(32 + n)), 32'(exp3[n]));
    check_c("full");

    // Norm going negative, then clipped by ReLU
    configure(3, 8'h64, 1, 8'h08, 8'h00, 8'h20);
    run_engine("norm", 1'b0);
    check_eq("norm C00", 32'(ram_a(32)), 32'hFE);
    configure(11, 8'h64, 1, 8'h08, 8'h00, 8'h20);
    run_engine("relu", 1'b0);
    check_eq("relu C00", 32'(ram_a(32)), 32'h00);

    // Start held high in DONE must not retrigger
    configure(1, 0, 0, 8'h08, 8'h00, 8'h50);
    apb_write(8'h04, 32'd1);
    wait_done("hold");
    host_wr(1'b0, 8'h50, 32'hA5A5A5A5);
    repeat (30) @(negedge clk);
    check_eq("hold no_rerun", 32'(ram_a(8'h50)), 32'hA5);
    apb_read(8'h04, d);
    check_eq("hold stdn", d, 32'h80000001);
    apb_write(8'h04, 32'd0);

    // Reset in the middle of COMPUTE
    for (int w = 0; w < 4; w++) host_wr(1'b0, 8'h60 + 4*w, 32'hC3C3C3C3 ^ 32'(w * 32'h01010101));
    for (int n = 0; n < 16; n++) keep[n] = ram_a(8'h60 + n);
    configure(1, 0, 0, 8'h08, 8'h00, 8'h60);
    apb_write(8'h04, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apb_read(8'h04, d);
    check_eq("rst stdn", d, 32'd0);
    repeat (20) @(negedge clk);
    for (int n = 0; n < 16; n++)
      check_eq($sformatf("rst keep[%0d]", n), 32'(ram_a(8'h60 + n)), 32'(keep[n]));
    configure(1, 0, 0, 8'h08, 8'h00, 8'h60);
    run_engine("after_rst", 1'b0);
    check_c("after_rst");

    // Randomized matrices, enables, norm parameters and placements
    for (int it = 0; it < 10; it++) begin
      hi = (it % 2 == 0) ? 127 : 15;
      lo = -hi - ((hi == 127) ? 1 : 0);
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) begin
          mA[i][k] = int'($urandom_range(0, hi - lo)) + lo;
          mB[i][k] = int'($urandom_range(0, hi - lo)) + lo;
        end
      en   = int'($urandom_range(0, 15));
      mean = int'($urandom_range(0, 255)) - 128;
      inv  = (it % 3 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 6)) - 3;
      aa   = 4 * int'($urandom_range(0, 252));
      ba   = 4 * int'($urandom_range(0, 252));
      ca   = 4 * int'($urandom_range(0, 252));
      load_A(aa);
      load_B(ba);
      configure(en, mean, inv, aa, ba, ca);
      run_engine($sformatf("rnd%0d", it), (it % 2) == 1);
      check_c($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
